// File: rtl/shift_pkg.sv
// Shared encodings for the universal shift register: operating modes and
// the shift-direction flag values used by the word counter.
package shift_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    localparam logic DIR_R = 1'b0;
    localparam logic DIR_L = 1'b1;

endpackage : shift_pkg

// File: rtl/usr_cell.sv
// One bit of the universal shift register: a synchronously reset flop fed by
// a 4:1 mux selecting hold, the left neighbour (shift right), the right
// neighbour (shift left) or the parallel-load bit.
module usr_cell
    import shift_pkg::*;
(
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       en_i,
    input  logic [1:0] mode_i,
    input  logic       left_i,
    input  logic       right_i,
    input  logic       pdata_i,
    output logic       q_o
);

    logic q_q;
    logic q_d;

    // Next-state mux: the clock enable gates every mode back to hold.
    always_comb begin
        q_d = q_q;
        if (en_i) begin
            case (mode_i)
                MODE_HOLD: q_d = q_q;
                MODE_SHR:  q_d = left_i;
                MODE_SHL:  q_d = right_i;
                MODE_LOAD: q_d = pdata_i;
                default:   q_d = q_q;
            endcase
        end else begin
            q_d = q_q;
        end
    end

    // Bit storage with synchronous reset to zero.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule : usr_cell

// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal shift register (hold / shift right / shift left /
// parallel load) with a serial word counter. Each run of WIDTH enabled
// same-direction shifts pulses word_valid and captures the post-shift
// register value into pout.
module univ_shift_reg
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] pdata,
    output logic [WIDTH-1:0] q,
    output logic             sout_r,
    output logic             sout_l,
    output logic             word_valid,
    output logic [WIDTH-1:0] pout
);

    localparam int unsigned     CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

    logic [WIDTH-1:0] q_s;
    logic [WIDTH-1:0] shr_s;
    logic [WIDTH-1:0] shl_s;

    logic             shift_req_s;
    logic             shift_dir_s;
    logic [WIDTH-1:0] shifted_s;
    logic [CNT_W-1:0] cnt_nxt_s;

    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             dir_q,   dir_d;
    logic             wv_q,    wv_d;
    logic [WIDTH-1:0] pout_q,  pout_d;

    // Shifted images of the register; bit i of each feeds cell i directly.
    assign shr_s = {sin_r, q_s[WIDTH-1:1]};
    assign shl_s = {q_s[WIDTH-2:0], sin_l};

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cell
            usr_cell u_cell (
                .clk_i   (clk),
                .reset_i (reset),
                .en_i    (en),
                .mode_i  (mode),
                .left_i  (shr_s[gi]),
                .right_i (shl_s[gi]),
                .pdata_i (pdata[gi]),
                .q_o     (q_s[gi])
            );
        end
    endgenerate

    // Decode whether this cycle shifts, in which direction, and the post-shift value.
    always_comb begin
        shift_req_s = 1'b0;
        shift_dir_s = dir_q;
        shifted_s   = q_s;
        if (en) begin
            case (mode)
                MODE_SHR: begin
                    shift_req_s = 1'b1;
                    shift_dir_s = DIR_R;
                    shifted_s   = shr_s;
                end
                MODE_SHL: begin
                    shift_req_s = 1'b1;
                    shift_dir_s = DIR_L;
                    shifted_s   = shl_s;
                end
                default: begin
                    shift_req_s = 1'b0;
                    shift_dir_s = dir_q;
                    shifted_s   = q_s;
                end
            endcase
        end else begin
            shift_req_s = 1'b0;
        end
    end

    // Word counter: a direction change restarts the word with the current bit
    // as bit one; reaching WIDTH completes the word and rearms the counter.
    always_comb begin
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        pout_d    = pout_q;
        wv_d      = 1'b0;
        cnt_nxt_s = cnt_q;
        if (shift_req_s) begin
            if (shift_dir_s == dir_q) begin
                cnt_nxt_s = cnt_q + CNT_ONE;
            end else begin
                cnt_nxt_s = CNT_ONE;
                dir_d     = shift_dir_s;
            end
            if (cnt_nxt_s == CNT_FULL) begin
                cnt_d  = CNT_ZERO;
                wv_d   = 1'b1;
                pout_d = shifted_s;
            end else begin
                cnt_d  = cnt_nxt_s;
            end
        end else if (en && (mode == MODE_LOAD)) begin
            cnt_d = CNT_ZERO;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter, direction flag and word outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= CNT_ZERO;
            dir_q  <= DIR_R;
            wv_q   <= 1'b0;
            pout_q <= {WIDTH{1'b0}};
        end else begin
            cnt_q  <= cnt_d;
            dir_q  <= dir_d;
            wv_q   <= wv_d;
            pout_q <= pout_d;
        end
    end

    assign q          = q_s;
    assign sout_r     = q_s[0];
    assign sout_l     = q_s[WIDTH-1];
    assign word_valid = wv_q;
    assign pout       = pout_q;

endmodule : univ_shift_reg

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg at WIDTH=4: the stimulus process pushes
// the hand-computed register state for every applied vector, and pushes the
// expected word whenever a completion is due; a monitor compares state every
// cycle and pops a word whenever the DUT raises word_valid.
module tb_univ_shift_reg;

    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] q;
        logic         wv;
        logic [W-1:0] pout;
    } snap_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         en = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic         sin_r = 1'b0;
    logic         sin_l = 1'b0;
    logic [W-1:0] pdata = 4'b0000;
    logic [W-1:0] q;
    logic         sout_r;
    logic         sout_l;
    logic         word_valid;
    logic [W-1:0] pout;

    snap_t        snap_q[$];
    logic [W-1:0] word_q[$];
    int           n_vec = 0;
    int           n_miss = 0;

    univ_shift_reg #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .mode       (mode),
        .sin_r      (sin_r),
        .sin_l      (sin_l),
        .pdata      (pdata),
        .q          (q),
        .sout_r     (sout_r),
        .sout_l     (sout_l),
        .word_valid (word_valid),
        .pout       (pout)
    );

    always #5 clk = ~clk;

    // Drive one vector just after a falling edge, record its expected result, take one rising edge.
    task automatic apply(input logic r, input logic e, input logic [1:0] m,
                         input logic sr, input logic sl, input logic [W-1:0] pd,
                         input logic [W-1:0] eq, input logic ewv, input logic [W-1:0] ep);
        snap_t s;
        @(negedge clk);
        #1;
        reset = r; en = e; mode = m; sin_r = sr; sin_l = sl; pdata = pd;
        s.q = eq; s.wv = ewv; s.pout = ep;
        snap_q.push_back(s);
        if (ewv) word_q.push_back(ep);
        @(posedge clk);
    endtask

    // Monitor: check the registered state after every edge and pop a word on word_valid.
    always @(negedge clk) begin
        if (word_valid) begin
            if (word_q.size() == 0) begin
                n_miss++;
                $display("FAIL word_unexpected: pout=%b with no word expected", pout);
            end else begin
                logic [W-1:0] w;
                w = word_q.pop_front();
                if (pout !== w) begin
                    n_miss++;
                    $display("FAIL word_pout: got %b expected %b", pout, w);
                end
            end
        end
        if (snap_q.size() != 0) begin
            snap_t s;
            s = snap_q.pop_front();
            n_vec++;
            if (q !== s.q) begin
                n_miss++;
                $display("FAIL vec%0d q: got %b expected %b", n_vec, q, s.q);
            end
            if (word_valid !== s.wv) begin
                n_miss++;
                $display("FAIL vec%0d word_valid: got %b expected %b", n_vec, word_valid, s.wv);
            end
            if (pout !== s.pout) begin
                n_miss++;
                $display("FAIL vec%0d pout: got %b expected %b", n_vec, pout, s.pout);
            end
            if (sout_r !== s.q[0]) begin
                n_miss++;
                $display("FAIL vec%0d sout_r: got %b expected %b", n_vec, sout_r, s.q[0]);
            end
            if (sout_l !== s.q[W-1]) begin
                n_miss++;
                $display("FAIL vec%0d sout_l: got %b expected %b", n_vec, sout_l, s.q[W-1]);
            end
        end
    end

    initial begin
        //     rst  en   mode   sr    sl    pdata    exp_q    wv    exp_pout
        // reset state
        apply(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000);
        // 1: right shifts 1,0,1,1
        apply(1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 4'b0000, 4'b1000, 1'b0, 4'b0000);
        apply(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 4'b0000, 4'b0100, 1'b0, 4'b0000);
        apply(1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 4'b0000, 4'b1010, 1'b0, 4'b0000);
        apply(1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 4'b0000, 4'b1101, 1'b1, 4'b1101);
        apply(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 4'b0000, 4'b1101, 1'b0, 4'b1101);
        // 2: clear by load, then left shifts 1,1,0,0
        apply(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b1101);
        apply(1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 4'b0000, 4'b0001, 1'b0, 4'b1101);
        apply(1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 4'b0000, 4'b0011, 1'b0, 4'b1101);
        apply(1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 4'b0000, 4'b0110, 1'b0, 4'b1101);
        apply(1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 4'b0000, 4'b1100, 1'b1, 4'b1100);
        // 3: two rights, then lefts with sin_l=1; the direction change restarts the count
        apply(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 4'b0000, 4'b0110, 1'b0, 4'b1100);
        apply(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 4'b0000, 4'b0011, 1'b0, 4'b1100);
        apply(1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 4'b0000, 4'b0111, 1'b0, 4'b1100);
        apply(1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 4'b0000, 4'b1111, 1'b0, 4'b1100);
        apply(1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 4'b0000, 4'b1111, 1'b0, 4'b1100);
        apply(1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 4'b0000, 4'b1111, 1'b1, 4'b1111);
        // 4: load 1010, hold x3, en=0 with shift-right mode x2
        apply(1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 4'b1010, 4'b1010, 1'b0, 4'b1111);
        for (int i = 0; i < 3; i++)
            apply(1'b0, 1'b1, 2'b00, 1'b1, 1'b1, 4'b0101, 4'b1010, 1'b0, 4'b1111);
        for (int i = 0; i < 2; i++)
            apply(1'b0, 1'b0, 2'b01, 1'b1, 1'b1, 4'b0101, 4'b1010, 1'b0, 4'b1111);
        // 5: three rights, reset mid-word, four rights of 1
        apply(1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 4'b0000, 4'b1101, 1'b0, 4'b1111);
        apply(1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 4'b0000, 4'b1110, 1'b0, 4'b1111);
        apply(1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 4'b0000, 4'b1111, 1'b0, 4'b1111);
        apply(1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000);
        apply(1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 4'b0000, 4'b1000, 1'b0, 4'b0000);
        apply(1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 4'b0000, 4'b1100, 1'b0, 4'b0000);
        apply(1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 4'b0000, 4'b1110, 1'b0, 4'b0000);
        apply(1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 4'b0000, 4'b1111, 1'b1, 4'b1111);
        // 6: eight continuous rights with one stall after the second
        apply(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 4'b0000, 4'b0111, 1'b0, 4'b1111);
        apply(1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 4'b0000, 4'b1011, 1'b0, 4'b1111);
        apply(1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 4'b0000, 4'b1011, 1'b0, 4'b1111);
        apply(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 4'b0000, 4'b0101, 1'b0, 4'b1111);
        apply(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 4'b0000, 4'b0010, 1'b1, 4'b0010);
        apply(1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 4'b0000, 4'b1001, 1'b0, 4'b0010);
        apply(1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 4'b0000, 4'b1100, 1'b0, 4'b0010);
        apply(1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 4'b0000, 4'b0110, 1'b0, 4'b0010);
        apply(1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 4'b0000, 4'b1011, 1'b1, 4'b1011);
        apply(1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 4'b0000, 4'b1011, 1'b0, 4'b1011);

        // drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 10 && snap_q.size() != 0; i++) @(negedge clk);
        #1;
        if (snap_q.size() != 0) begin
            n_miss++;
            $display("FAIL drain: %0d vectors left unchecked, expected 0", snap_q.size());
        end
        if (word_q.size() != 0) begin
            n_miss++;
            $display("FAIL words: %0d expected words never seen, expected 0", word_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_univ_shift_reg
